// File: rtl/mips_mem_waitstate.sv
// Separate instruction and data word memories for a MIPS core. The data port
// inserts a configurable number of wait states, flags illegal requests and counts completed accesses.
module mips_mem_waitstate #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] INSTR_BASE  = 32'hBFC00000,
  parameter logic [31:0] DATA_BASE   = 32'h00000000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_byteenable,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        data_waitrequest,
  output logic        data_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WLOAD = 4'(WAIT_CYCLES - 1);
  localparam logic [15:0] CMAX  = 16'hFFFF;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  logic [31:0] imem_q [DEPTH_WORDS];
  logic [31:0] dmem_q [DEPTH_WORDS];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] rd_cnt_q, wr_cnt_q;

  logic [31:0]   ioff, doff;
  logic [AW-1:0] iidx, didx;
  logic          req, bad, valid, complete_c, do_write_c;
  logic          unused_bits;

  // Offsets wrap below the base, so one unsigned compare covers both bounds.
  assign ioff = instr_address - INSTR_BASE;
  assign doff = data_address - DATA_BASE;
  assign iidx = ioff[AW+1:2];
  assign didx = doff[AW+1:2];
  assign unused_bits = ^{ioff[1:0], doff[1:0]};

  assign instr_readdata = (ioff < SPAN) ? imem_q[iidx] : 32'h0;

  assign req   = data_read | data_write;
  assign bad   = (data_read & data_write) | ~(doff < SPAN);
  assign valid = req & ~bad;

  // Wait-state sequencing; a request that goes away mid-access abandons it.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    complete_c       = 1'b0;
    data_waitrequest = 1'b0;
    data_err         = 1'b0;
    if (reset) begin
      data_err = req & bad;
      if (WAIT_CYCLES == 0) begin
        complete_c = valid;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (valid) begin
              data_waitrequest = 1'b1;
              if (WAIT_CYCLES == 1) begin
                state_d = S_DONE;
              end else begin
                state_d = S_WAIT;
                cnt_d   = WLOAD;
              end
            end
          end
          S_WAIT: begin
            if (valid) begin
              data_waitrequest = 1'b1;
              cnt_d            = cnt_q - 4'd1;
              if (cnt_q == 4'd1) state_d = S_DONE;
            end else begin
              state_d = S_IDLE;
            end
          end
          S_DONE: begin
            complete_c = valid;
            state_d    = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  assign do_write_c    = complete_c & data_write;
  assign data_readdata = (complete_c & data_read) ? dmem_q[didx] : 32'h0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (complete_c && data_read && rd_cnt_q != CMAX) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (do_write_c && wr_cnt_q != CMAX) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  // Memory contents survive reset; only enabled byte lanes are written.
  always_ff @(posedge clk) begin
    if (do_write_c) begin
      for (int b = 0; b < 4; b++) begin
        if (data_byteenable[b]) dmem_q[didx][8*b +: 8] <= data_writedata[8*b +: 8];
      end
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;

endmodule
